seven_segment_driver: RTL and testbench

SEVEN_SEGMENT_DRIVER -- requirements
Module: seven_segment_driver

---
 rtl/seven_segment_pkg.sv | 35 +++
 rtl/seven_segment_encode.sv | 32 +++
 rtl/seven_segment_driver.sv | 200 ++++++++++++++++++++
 tb/tb_seven_segment_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// -----------------------------------------------------------------------------
// seven_segment_pkg
// Shared definitions for the seven-segment display driver:
//   - active-low segment codes, bit order a..g (bit 6 = a, bit 0 = g)
//   - FSM state enum for the conversion controller
//   - helper that sizes the BCD register for a given binary width
// -----------------------------------------------------------------------------
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

  // Decimal digits needed for the largest unsigned value of 'width' bits:
  // floor(width * log10(2)) + 1, with log10(2) approximated as 0.30103.
  function automatic int bcd_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/seven_segment_encode.sv
// -----------------------------------------------------------------------------
// seven_segment_encode
// Converts one 4-bit BCD digit into an active-low segment code (a..g).
// Codes 10..15 never occur in valid BCD and map to all segments off.
// Ports:
//   bcd  in   4-bit BCD digit
//   seg  out  7-bit active-low segment pattern
// -----------------------------------------------------------------------------
module seven_segment_encode
  import seven_segment_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_driver.sv
// -----------------------------------------------------------------------------
// seven_segment_driver
// Accepts a binary number over a valid/ready handshake, converts it to BCD
// with an iterative double-dabble (one bit per clock), and publishes the
// segment codes for all digits in parallel. A free-running scanner also
// multiplexes the digits onto one segment bus for a common-cathode/anode
// display.
// Ports:
//   clk       in   clock, all logic on the rising edge
//   reset     in   synchronous active-high reset
//   number    in   WIDTH-bit value to display (two's complement if SIGNED=1)
//   in_valid  in   number is valid
//   in_ready  out  driver is idle and will accept number
//   displays  out  DIGITS x 7 active-low segment codes, digit 0 least significant
//   done      out  one-cycle pulse when displays update
//   overflow  out  last value needed more than DIGITS digits (sign included)
//   scan_seg  out  segments of the currently scanned digit
//   scan_sel  out  active-low one-hot enable of the scanned digit
// -----------------------------------------------------------------------------
module seven_segment_driver
  import seven_segment_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 8,
  parameter int SIGNED      = 0,
  parameter int BLANK_ZEROS = 1,
  parameter int SCAN_DIV    = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       number,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DIGITS-1:0][6:0] displays,
  output logic                   done,
  output logic                   overflow,
  output logic [6:0]             scan_seg,
  output logic [DIGITS-1:0]      scan_sel
);

  localparam int ND = bcd_digits(WIDTH);                // BCD digits produced
  localparam int NP = (ND > DIGITS) ? ND : DIGITS;      // padded digit count
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(NP + 2);                   // holds msd+2
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t            state;
  logic [WIDTH-1:0]  bin;
  logic [4*ND-1:0]   bcd;
  logic [4*ND-1:0]   bcd_adj;
  logic [4*NP-1:0]   bcd_pad;
  logic [CW-1:0]     cnt;
  logic              neg;

  logic              is_neg;
  logic [WIDTH-1:0]  mag;
  logic [IW-1:0]     msd;
  logic [IW-1:0]     used;
  logic              ovf;
  logic [DIGITS-1:0][6:0] enc;
  logic [DIGITS-1:0][6:0] next_disp;

  // ---------------------------------------------------------------------------
  // Input magnitude. Negating the most negative value yields 100..0, which is
  // the correct magnitude when read back as unsigned.
  // ---------------------------------------------------------------------------
  assign is_neg = (SIGNED != 0) && number[WIDTH-1];
  assign mag    = is_neg ? (~number + WIDTH'(1)) : number;

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    // NOTE: default assignment first so every path writes the signal and no
    // latch is inferred.
    bcd_adj = bcd;
    for (int i = 0; i < ND; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Zero-extend the BCD result so every display digit has an encoder input
  // even when the binary width yields fewer digits than the display has.
  always_comb begin
    bcd_pad          = '0;
    bcd_pad[4*ND-1:0] = bcd;
  end

  // Index of the most significant nonzero digit (0 for value 0).
  always_comb begin
    msd = '0;
    for (int i = 0; i < ND; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = IW'(i);
    end
  end

  assign used = msd + IW'(1) + IW'(neg);
  assign ovf  = used > IW'(DIGITS);

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seven_segment_encode u_encode (
      .bcd (bcd_pad[4*g +: 4]),
      .seg (enc[g])
    );
  end

  // Display composition: overflow fills with minus; otherwise digits above
  // the msd are blanked (or shown as zeros) and the sign is placed either
  // just above the msd or in the top digit.
  always_comb begin
    next_disp = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf) begin
        next_disp[i] = SEG_MINUS;
      end else if (BLANK_ZEROS != 0) begin
        if (IW'(i) <= msd)                        next_disp[i] = enc[i];
        else if (neg && (IW'(i) == msd + IW'(1))) next_disp[i] = SEG_MINUS;
        else                                      next_disp[i] = SEG_OFF;
      end else begin
        if (neg && (i == DIGITS - 1)) next_disp[i] = SEG_MINUS;
        else                          next_disp[i] = enc[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM. Accept at edge 0, shift at edges 1..WIDTH, publish at
  // edge WIDTH+1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
      displays <= {DIGITS{SEG_OFF}};
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= CONVERT;
            in_ready <= 1'b0;
            bin      <= mag;
            neg      <= is_neg;
            bcd      <= '0;
            cnt      <= '0;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= UPDATE;
        end
        UPDATE: begin
          displays <= next_disp;
          overflow <= ovf;
          done     <= 1'b1;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running digit scanner. scan_sel and scan_seg are both registered from
  // the same index, so they always refer to the same digit.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] scan_idx;
  logic [DW-1:0] scan_div;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx <= '0;
      scan_div <= '0;
      scan_sel <= ~DIGITS'(1);
      scan_seg <= SEG_OFF;
    end else begin
      if (scan_div == DW'(SCAN_DIV - 1)) begin
        scan_div <= '0;
        scan_idx <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + SW'(1);
      end else begin
        scan_div <= scan_div + DW'(1);
      end
      scan_sel <= ~(DIGITS'(1) << scan_idx);
      scan_seg <= displays[scan_idx];
    end
  end

endmodule

// File: tb/tb_seven_segment_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_driver
// Three instances share clock, reset and the input handshake:
//   u_u : unsigned, leading zeros blanked
//   u_s : signed,   leading zeros blanked
//   u_z : signed,   leading zeros shown
// A table of numbers with hand-computed segment images drives the main checks;
// hand-written sequences cover handshake hold-off, reset abort and scanning.
// -----------------------------------------------------------------------------
module tb_seven_segment_driver;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S7 = 7'b0001111, S9 = 7'b0001100,
                         SM = 7'b1111110, SO = 7'b1111111;
  localparam logic [55:0] ALL_M   = {8{SM}};
  localparam logic [55:0] ALL_OFF = {8{SO}};
  localparam int LAT = 33;  // WIDTH + 1

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] number = '0;
  logic in_valid = 1'b0;

  logic rdy_u, rdy_s, rdy_z, done_u, done_s, done_z, ov_u, ov_s, ov_z;
  logic [7:0][6:0] disp_u, disp_s, disp_z;
  logic [6:0] seg_u, seg_s, seg_z;
  logic [7:0] sel_u, sel_s, sel_z;

  always #5 clk = ~clk;

  seven_segment_driver #(.WIDTH(32), .DIGITS(8), .SIGNED(0), .BLANK_ZEROS(1), .SCAN_DIV(4)) u_u (
    .clk(clk), .reset(reset), .number(number), .in_valid(in_valid), .in_ready(rdy_u),
    .displays(disp_u), .done(done_u), .overflow(ov_u), .scan_seg(seg_u), .scan_sel(sel_u));
  seven_segment_driver #(.WIDTH(32), .DIGITS(8), .SIGNED(1), .BLANK_ZEROS(1), .SCAN_DIV(4)) u_s (
    .clk(clk), .reset(reset), .number(number), .in_valid(in_valid), .in_ready(rdy_s),
    .displays(disp_s), .done(done_s), .overflow(ov_s), .scan_seg(seg_s), .scan_sel(sel_s));
  seven_segment_driver #(.WIDTH(32), .DIGITS(8), .SIGNED(1), .BLANK_ZEROS(0), .SCAN_DIV(4)) u_z (
    .clk(clk), .reset(reset), .number(number), .in_valid(in_valid), .in_ready(rdy_z),
    .displays(disp_z), .done(done_z), .overflow(ov_z), .scan_seg(seg_z), .scan_sel(sel_z));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for done on u_u, counting posedges; k = -1 on timeout.
  task automatic wait_done(output int k);
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done_u) begin
        k = i;
        break;
      end
    end
    if (k < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
  endtask

  // One handshake transfer; returns the accept-to-done latency in cycles.
  task automatic send(input logic [31:0] n, output int k);
    @(negedge clk);
    number   = n;
    in_valid = 1'b1;
    check("ready_before_accept", rdy_u, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("ready_while_busy", rdy_u, 1'b0);
    wait_done(k);
  endtask

  typedef struct {
    logic [31:0] num;
    logic [55:0] du; logic ou;
    logic [55:0] ds; logic os;
    logic [55:0] dz; logic oz;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int k;
    logic [55:0] exp_img;
    logic [7:0] prev, cur;
    int run, idx;
    bit first;
    int done_seen;

    vecs[0]  = '{32'd12345,
                 {SO,SO,SO,S1,S2,S3,S4,S5}, 1'b0,
                 {SO,SO,SO,S1,S2,S3,S4,S5}, 1'b0,
                 {S0,S0,S0,S1,S2,S3,S4,S5}, 1'b0};
    vecs[1]  = '{32'hFFFF_FFD6,              // -42
                 ALL_M, 1'b1,
                 {SO,SO,SO,SO,SO,SM,S4,S2}, 1'b0,
                 {SM,S0,S0,S0,S0,S0,S4,S2}, 1'b0};
    vecs[2]  = '{32'hFFFF_FFFF,              // 4294967295 / -1
                 ALL_M, 1'b1,
                 {SO,SO,SO,SO,SO,SO,SM,S1}, 1'b0,
                 {SM,S0,S0,S0,S0,S0,S0,S1}, 1'b0};
    vecs[3]  = '{32'd7,
                 {SO,SO,SO,SO,SO,SO,SO,S7}, 1'b0,
                 {SO,SO,SO,SO,SO,SO,SO,S7}, 1'b0,
                 {S0,S0,S0,S0,S0,S0,S0,S7}, 1'b0};
    vecs[4]  = '{32'd0,
                 {SO,SO,SO,SO,SO,SO,SO,S0}, 1'b0,
                 {SO,SO,SO,SO,SO,SO,SO,S0}, 1'b0,
                 {8{S0}}, 1'b0};
    vecs[5]  = '{32'd99999999, {8{S9}}, 1'b0, {8{S9}}, 1'b0, {8{S9}}, 1'b0};
    vecs[6]  = '{32'd100000000, ALL_M, 1'b1, ALL_M, 1'b1, ALL_M, 1'b1};
    vecs[7]  = '{32'hFF67_6981,              // -9999999: sign fits in digit 7
                 ALL_M, 1'b1,
                 {SM,S9,S9,S9,S9,S9,S9,S9}, 1'b0,
                 {SM,S9,S9,S9,S9,S9,S9,S9}, 1'b0};
    vecs[8]  = '{32'hFF67_6980,              // -10000000: sign does not fit
                 ALL_M, 1'b1, ALL_M, 1'b1, ALL_M, 1'b1};
    vecs[9]  = '{32'h8000_0000,              // most negative
                 ALL_M, 1'b1, ALL_M, 1'b1, ALL_M, 1'b1};
    vecs[10] = '{32'd1000,
                 {SO,SO,SO,SO,S1,S0,S0,S0}, 1'b0,
                 {SO,SO,SO,SO,S1,S0,S0,S0}, 1'b0,
                 {S0,S0,S0,S0,S1,S0,S0,S0}, 1'b0};
    vecs[11] = '{32'hFFFF_FFFB,              // -5
                 ALL_M, 1'b1,
                 {SO,SO,SO,SO,SO,SO,SM,S5}, 1'b0,
                 {SM,S0,S0,S0,S0,S0,S0,S5}, 1'b0};

    // Reset state, sampled while reset is still held.
    repeat (3) @(negedge clk);
    check("rst_ready",    rdy_u,  1'b1);
    check("rst_done",     done_u, 1'b0);
    check("rst_overflow", ov_u,   1'b0);
    check("rst_disp_u",   disp_u, ALL_OFF);
    check("rst_disp_s",   disp_s, ALL_OFF);
    check("rst_sel",      sel_u,  8'hFE);
    check("rst_seg",      seg_u,  SO);
    reset = 1'b0;

    // Table-driven conversions.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].num, k);
      check($sformatf("v%0d_latency", i), k, LAT);
      check($sformatf("v%0d_ready_at_done", i), rdy_u, 1'b1);
      check($sformatf("v%0d_disp_u", i), disp_u, vecs[i].du);
      check($sformatf("v%0d_ov_u", i),   ov_u,   vecs[i].ou);
      check($sformatf("v%0d_disp_s", i), disp_s, vecs[i].ds);
      check($sformatf("v%0d_ov_s", i),   ov_s,   vecs[i].os);
      check($sformatf("v%0d_disp_z", i), disp_z, vecs[i].dz);
      check($sformatf("v%0d_ov_z", i),   ov_z,   vecs[i].oz);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), done_u, 1'b0);
    end

    // in_valid held through CONVERT with a changed number: the new number
    // waits until the driver is idle again.
    @(negedge clk);
    number   = 32'd777;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    number = 32'd555;
    wait_done(k);
    check("hold_first_latency", k, LAT);
    check("hold_first_disp", disp_u, {SO,SO,SO,SO,SO,S7,S7,S7});
    @(posedge clk);                 // idle again: 555 accepted here
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(k);
    check("hold_second_latency", k, LAT);
    check("hold_second_disp", disp_u, {SO,SO,SO,SO,SO,S5,S5,S5});

    // Scanner: dwell of 4 cycles per digit, rotation with wrap, and the
    // segment bus carrying the selected digit.
    send(32'd12345, k);
    check("scan_load_latency", k, LAT);
    exp_img = {SO,SO,SO,S1,S2,S3,S4,S5};
    @(negedge clk);
    prev  = sel_u;
    run   = 1;
    first = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      cur = sel_u;
      if (cur != prev) begin
        check("scan_step", cur, {prev[6:0], prev[7]});
        if (!first) check("scan_dwell", run, 4);
        first = 1'b0;
        run   = 1;
      end else begin
        run++;
      end
      idx = 0;
      for (int b = 0; b < 8; b++) if (!cur[b]) idx = b;
      check("scan_seg", seg_u, exp_img[idx*7 +: 7]);
      prev = cur;
    end

    // Reset at cycle 10 of CONVERT aborts the conversion.
    @(negedge clk);
    number   = 32'd4321;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", rdy_u, 1'b1);
    done_seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done_u || done_s || done_z) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_disp_u", disp_u, ALL_OFF);
    check("abort_disp_s", disp_s, ALL_OFF);
    check("abort_disp_z", disp_z, ALL_OFF);
    check("abort_overflow", ov_u, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
